alu_operand_path: RTL and testbench

//  Execute-stage slice of the single-cycle RV32 core: selects the ALU B operand (I-imm, S-imm, rs2),

---
 rtl/alu_operand_pkg.sv | 20 ++
 rtl/alu_operand_path_alu_core.sv | 45 ++++
 rtl/alu_operand_path.sv | 93 +++++++++
 tb/tb_alu_operand_path.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/alu_operand_pkg.sv
// Shared types and constants for the execute-stage operand path.
// Optional feature macro: ALU_OVERFLOW_FLAG_EN (adds ovf/ovf_q outputs).
package alu_operand_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    BSEL_IMM_I = 2'b00,
    BSEL_IMM_S = 2'b01,
    BSEL_RS2   = 2'b10,
    BSEL_ZERO  = 2'b11
  } bsel_e;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } aluop_e;

endpackage

// File: rtl/alu_operand_path_alu_core.sv
// ADD/SUB core with the zero flag (and signed overflow when ALU_OVERFLOW_FLAG_EN is defined).
// Results wrap modulo 2^XLEN; the carry and borrow are dropped.
module alu_core #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] doa,
  input  logic [XLEN-1:0] b,
  input  logic            control_alu,
  output logic [XLEN-1:0] alu_out,
  output logic            cero
`ifdef ALU_OVERFLOW_FLAG_EN
  ,
  output logic            ovf
`endif
);
  import alu_operand_pkg::*;

  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_diff;

  assign w_sum  = doa + b;
  assign w_diff = doa - b;

  // Pick the add or subtract result and derive the zero flag from it
  always_comb begin
    alu_out = w_sum;
    if (aluop_e'(control_alu) == ALU_SUB) begin
      alu_out = w_diff;
    end
    cero = (alu_out == '0);
  end

`ifdef ALU_OVERFLOW_FLAG_EN
  // Signed overflow: the operand sign pattern is checked against the sign of the result
  always_comb begin
    ovf = 1'b0;
    if (aluop_e'(control_alu) == ALU_SUB) begin
      ovf = (doa[XLEN-1] != b[XLEN-1]) && (alu_out[XLEN-1] != doa[XLEN-1]);
    end else begin
      ovf = (doa[XLEN-1] == b[XLEN-1]) && (alu_out[XLEN-1] != doa[XLEN-1]);
    end
  end
`endif

endmodule

// File: rtl/alu_operand_path.sv
// Execute-stage operand path: B-operand select, ADD/SUB, zero flag, PC increment select.
// The datapath is combinational; only the flag copies are clocked.
// Optional feature macro: ALU_OVERFLOW_FLAG_EN (adds ovf/ovf_q outputs).
module alu_operand_path #(
  parameter int              XLEN   = 32,
  parameter logic [XLEN-1:0] PC_INC = 32'd4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] doa,
  input  logic [XLEN-1:0] dob,
  input  logic [XLEN-1:0] imm_ex,
  input  logic [XLEN-1:0] imm_sw,
  input  logic [1:0]      s_mux_b,
  input  logic            control_alu,
  input  logic [XLEN-1:0] i_branch,
  input  logic            s_mux_a,
  output logic [XLEN-1:0] alu_out,
  output logic            cero,
  output logic            cero_q,
  output logic [XLEN-1:0] op_pc
`ifdef ALU_OVERFLOW_FLAG_EN
  ,
  output logic            ovf,
  output logic            ovf_q
`endif
);
  import alu_operand_pkg::*;

  logic [XLEN-1:0] w_operandB;
  logic            r_ceroQ;

  // B operand select; the spare code yields a defined zero operand
  always_comb begin
    w_operandB = '0;
    case (bsel_e'(s_mux_b))
      BSEL_IMM_I: w_operandB = imm_ex;
      BSEL_IMM_S: w_operandB = imm_sw;
      BSEL_RS2:   w_operandB = dob;
      BSEL_ZERO:  w_operandB = '0;
      default:    w_operandB = '0;
    endcase
  end

  alu_core #(
    .XLEN(XLEN)
  ) u_aluCore (
    .doa        (doa),
    .b          (w_operandB),
    .control_alu(control_alu),
    .alu_out    (alu_out),
    .cero       (cero)
`ifdef ALU_OVERFLOW_FLAG_EN
    ,
    .ovf        (ovf)
`endif
  );

  // PC increment: sequential step or branch offset, offset passed unaligned as-is
  always_comb begin
    op_pc = PC_INC;
    if (s_mux_a) begin
      op_pc = i_branch;
    end
  end

  // Registered zero flag for the clocked control unit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ceroQ <= 1'b0;
    end else begin
      r_ceroQ <= cero;
    end
  end

  assign cero_q = r_ceroQ;

`ifdef ALU_OVERFLOW_FLAG_EN
  logic r_ovfQ;

  // Registered overflow flag, cleared with the zero flag on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovfQ <= 1'b0;
    end else begin
      r_ovfQ <= ovf;
    end
  end

  assign ovf_q = r_ovfQ;
`endif

endmodule

// File: tb/tb_alu_operand_path.sv
// Directed testbench for alu_operand_path with hand-computed expected values.
// Overflow checks are compiled in when ALU_OVERFLOW_FLAG_EN is defined.
module tb_alu_operand_path;

  logic        clk;
  logic        rst_n;
  logic [31:0] doa;
  logic [31:0] dob;
  logic [31:0] imm_ex;
  logic [31:0] imm_sw;
  logic [1:0]  s_mux_b;
  logic        control_alu;
  logic [31:0] i_branch;
  logic        s_mux_a;
  logic [31:0] alu_out;
  logic        cero;
  logic        cero_q;
  logic [31:0] op_pc;
`ifdef ALU_OVERFLOW_FLAG_EN
  logic        ovf;
  logic        ovf_q;
`endif

  int checkCount;
  int errorCount;

  alu_operand_path dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .doa        (doa),
    .dob        (dob),
    .imm_ex     (imm_ex),
    .imm_sw     (imm_sw),
    .s_mux_b    (s_mux_b),
    .control_alu(control_alu),
    .i_branch   (i_branch),
    .s_mux_a    (s_mux_a),
    .alu_out    (alu_out),
    .cero       (cero),
    .cero_q     (cero_q),
    .op_pc      (op_pc)
`ifdef ALU_OVERFLOW_FLAG_EN
    ,
    .ovf        (ovf),
    .ovf_q      (ovf_q)
`endif
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b2, input logic [31:0] immI,
                               input logic [31:0] immS, input logic [1:0] sel, input logic op);
    doa         = a;
    dob         = b2;
    imm_ex      = immI;
    imm_sw      = immS;
    s_mux_b     = sel;
    control_alu = op;
    #1;
  endtask

  // Advance through one rising edge and settle just after it
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount  = 0;
    errorCount  = 0;
    rst_n       = 1'b0;
    i_branch    = 32'h0;
    s_mux_a     = 1'b0;
    applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0);
    stepClock();
    checkOutput("reset_cero_q", {31'b0, cero_q}, 32'h0);
`ifdef ALU_OVERFLOW_FLAG_EN
    checkOutput("reset_ovf_q", {31'b0, ovf_q}, 32'h0);
`endif
    rst_n = 1'b1;

    // I-immediate add: 10 + 5
    applyStimulus(32'd10, 32'd99, 32'd5, 32'd7, 2'b00, 1'b0);
    checkOutput("addi_out", alu_out, 32'd15);
    checkOutput("addi_cero", {31'b0, cero}, 32'h0);
    stepClock();
    checkOutput("addi_cero_q", {31'b0, cero_q}, 32'h0);

    // rs2 subtract of equal values: zero result
    applyStimulus(32'h1234, 32'h1234, 32'h1, 32'h2, 2'b10, 1'b1);
    checkOutput("sub_eq_out", alu_out, 32'h0);
    checkOutput("sub_eq_cero", {31'b0, cero}, 32'h1);
    stepClock();
    checkOutput("sub_eq_cero_q", {31'b0, cero_q}, 32'h1);

    // Reset mid-operation: flag clears, combinational outputs keep tracking
    rst_n = 1'b0;
    stepClock();
    checkOutput("rst_mid_cero_q", {31'b0, cero_q}, 32'h0);
    checkOutput("rst_mid_out", alu_out, 32'h0);
    checkOutput("rst_mid_cero", {31'b0, cero}, 32'h1);
    rst_n = 1'b1;
    stepClock();
    checkOutput("rst_rel_cero_q", {31'b0, cero_q}, 32'h1);

    // S-immediate add of -4
    applyStimulus(32'h100, 32'h50, 32'h8, 32'hFFFFFFFC, 2'b01, 1'b0);
    checkOutput("adds_out", alu_out, 32'h000000FC);
    // Zero select passes doa through
    applyStimulus(32'h100, 32'h50, 32'h8, 32'hFFFFFFFC, 2'b11, 1'b0);
    checkOutput("zero_sel_out", alu_out, 32'h100);
    applyStimulus(32'h100, 32'h50, 32'h8, 32'hFFFFFFFC, 2'b11, 1'b1);
    checkOutput("zero_sel_sub", alu_out, 32'h100);

    // rs2 subtract, nonzero result
    applyStimulus(32'h10, 32'h3, 32'h1, 32'h2, 2'b10, 1'b1);
    checkOutput("sub_rs2_out", alu_out, 32'hD);
    checkOutput("sub_rs2_cero", {31'b0, cero}, 32'h0);
    stepClock();
    checkOutput("sub_rs2_cero_q", {31'b0, cero_q}, 32'h0);

    // Wrap-around both ways
    applyStimulus(32'h7FFFFFFF, 32'h0, 32'h1, 32'h2, 2'b00, 1'b0);
    checkOutput("wrap_add_out", alu_out, 32'h80000000);
    checkOutput("wrap_add_cero", {31'b0, cero}, 32'h0);
`ifdef ALU_OVERFLOW_FLAG_EN
    checkOutput("wrap_add_ovf", {31'b0, ovf}, 32'h1);
    stepClock();
    checkOutput("wrap_add_ovf_q", {31'b0, ovf_q}, 32'h1);
    applyStimulus(32'h80000000, 32'h0, 32'h1, 32'h2, 2'b00, 1'b1);
    checkOutput("sub_ovf_out", alu_out, 32'h7FFFFFFF);
    checkOutput("sub_ovf", {31'b0, ovf}, 32'h1);
    applyStimulus(32'h5, 32'h0, 32'h3, 32'h2, 2'b00, 1'b0);
    checkOutput("no_ovf", {31'b0, ovf}, 32'h0);
`endif
    applyStimulus(32'h0, 32'h0, 32'h1, 32'h2, 2'b00, 1'b1);
    checkOutput("wrap_sub_out", alu_out, 32'hFFFFFFFF);
    checkOutput("wrap_sub_cero", {31'b0, cero}, 32'h0);

    // PC increment select, including an unaligned offset
    s_mux_a  = 1'b0;
    i_branch = 32'hFFFFFFF8;
    #1;
    checkOutput("op_pc_seq", op_pc, 32'd4);
    s_mux_a = 1'b1;
    #1;
    checkOutput("op_pc_branch", op_pc, 32'hFFFFFFF8);
    i_branch = 32'h00000011;
    #1;
    checkOutput("op_pc_odd", op_pc, 32'h00000011);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
